gpio: RTL
=========

# gpio

Memory-mapped general-purpose I/O peripheral on the SoC AXI4 peripheral bus, instanced beside UART, Timer and mtimer under the riscv_tcm_top master port. It drives up to 32 output pins with per-bit output enable and samples up to 32 input pins through a two-flop synchroniser. It latches per-bit edge events into a write-1-to-clear status register and raises a level interrupt into `intr_i`.

## Interface
- `addrBase`, `32'h0`: base address of the 32-byte register window; must be 32-byte aligned.
- `GPIO_W`, 32: number of implemented pins, 1..32; register bits at and above `GPIO_W` read 0 and ignore writes.
- `Clk`  in  1  system clock; single clock domain.
- `Rst`  in  1  synchronous, active-high reset.
- `axiBus`  AXI4bus.Slave  dw=32/aw=32/sw=4  register access; only the aw/w/b/ar/r valid, ready, addr, data, strb and resp fields are used.
- `gpio_i`  in  GPIO_W  asynchronous pin inputs.
- `gpio_o`  out  GPIO_W  pin output values; equals the DATA_OUT register.
- `gpio_oe`  out  GPIO_W  per-pin output enable; equals the OE register.
- `Int`  out  1  registered interrupt, `|(IRQ_STAT & IRQ_EN)`.

## Operation
- Decode: access hits when `addr[31:5] == addrBase[31:5]`. Offset is `addr[4:2]`. On a miss, no ready is asserted and the transaction is left to other slaves.
- Register map:
  - 0x00 DATA_OUT: RW.
  - 0x04 OE: RW.
  - 0x08 DATA_IN: RO, synchronised pins.
  - 0x0C IRQ_EN: RW.
  - 0x10 IRQ_EDGE: RW; 1 = rising edge, 0 = falling edge.
  - 0x14 IRQ_STAT: W1C.
  - 0x18 OUT_SET: WO; writing 1 sets DATA_OUT bits.
  - 0x1C OUT_CLR: WO; writing 1 clears DATA_OUT bits.
- Write data handling:
  - Byte lanes with `wstrb[n]=0` leave bits `[8n+7:8n]` untouched for every register type.
  - Writes to DATA_IN are ignored and return OKAY.
  - OUT_SET and OUT_CLR read as 0.
- Synchroniser: `s1 <= gpio_i`, `s2 <= s1`, `s3 <= s2`; DATA_IN reads `s2`.
- Edge detection: a rise is `s2 & ~s3`, a fall is `~s2 & s3`. Event per bit = rise when IRQ_EDGE=1, fall when IRQ_EDGE=0.
- IRQ_STAT latching:
  - A status bit sets on an event regardless of IRQ_EN; only `Int` is gated by IRQ_EN.
  - An event and a W1C clear of the same bit in the same cycle leave the bit set (set wins).
- Write FSM (IDLE/RESP):
  - IDLE: when `awvalid && wvalid && hit`, pulse `awready` and `wready` high for one cycle and update the register on that edge. Next state is RESP with `bvalid=1`, `bresp=2'b00`.
  - RESP: hold `bvalid` until `bready`, then return to IDLE.
  - A lone awvalid or wvalid is not accepted.
- Read FSM (IDLE/RESP):
  - IDLE: when `arvalid && hit`, pulse `arready` for one cycle and register `rdata` from the current register values. Next state is RESP with `rvalid=1`, `rresp=2'b00`.
  - RESP: hold `rvalid` and `rdata` stable until `rready`.
- Read and write FSMs run independently. A same-cycle read and write of the same register return the pre-write value.
- OUT_SET and OUT_CLR modify DATA_OUT only through the write path, so they cannot collide with each other.

## Timing
- Reset values:
  - All registers, `s1`/`s2`/`s3`, `gpio_o`, `gpio_oe` and `Int` are 0.
  - `awready`, `wready`, `bvalid`, `arready` and `rvalid` are 0; `rdata` and `bresp`/`rresp` are 0.
  - Both FSMs are in IDLE.
- Reset mid-transaction aborts the transaction: valids drop next cycle and no response is issued.
- Pins sampled high after reset produce a rising-edge event 2 cycles later. Software clears IRQ_STAT before setting IRQ_EN.
- Write latency:
  - Accept at edge A; `gpio_o`/`gpio_oe` update at edge A.
  - `bvalid` is high from A until the edge where `bready` is seen.
  - Minimum spacing between writes is 2 cycles.
- Read latency: `arready` at edge A, `rvalid` high from A. Minimum spacing between reads is 2 cycles.
- Input latency for a pin change captured by `s1` at edge k:
  - DATA_IN reflects it after edge k+1.
  - IRQ_STAT sets at edge k+2.
  - `Int` rises at edge k+3 if enabled.
- Pulses shorter than one clock may be missed. Edges are detected at most once per clock.
- `Int` falls one cycle after the W1C or IRQ_EN write edge that removes the last active bit.

## Test plan
- Reset, then read all 8 offsets (GPIO_W=32) -> every rdata is 0x00000000 with rresp=0; `gpio_o`=0, `gpio_oe`=0, `Int`=0.
- Output registers:
  - Write DATA_OUT=0xA5A5A5A5 with wstrb=4'b0011 -> DATA_OUT=0x0000A5A5.
  - OUT_SET 0xFF000000 -> DATA_OUT=0xFF00A5A5.
  - OUT_CLR 0x00000005 -> DATA_OUT=0xFF00A5A0; `gpio_o` matches.
  - OUT_SET and OUT_CLR read back 0.
- Edge interrupt:
  - Set IRQ_EDGE=0x1, IRQ_EN=0x1, drive `gpio_i[0]` 0->1 -> DATA_IN[0]=1, IRQ_STAT=0x1 at k+2, `Int`=1 at k+3.
  - Write IRQ_STAT=0x1 -> `Int`=0 one cycle later.
  - A falling edge on bit 0 sets nothing.
- W1C/event collision: time a W1C of bit 3 on the same edge as a bit-3 event -> IRQ_STAT[3] stays 1.
- Handshake back-pressure:
  - Hold `bready`=0 and `rready`=0 for 10 cycles -> `bvalid`/`rvalid` and `rdata` stay stable and no second transaction is accepted.
  - Address addrBase+0x20 -> no ready asserted.
- Assert `Rst` while `bvalid`=1 -> `bvalid`=0 and DATA_OUT=0 on the next edge.

Source files
------------

// File: rtl/gpio_if.sv
// AXI4 register-access bus between the peripheral master port and its slaves.
// Only the fields a single-beat register slave needs are carried.
interface AXI4bus #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int SW = 4
);
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    modport Slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport Master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/gpio.sv
// Memory-mapped GPIO: output data/enable registers, synchronised inputs,
// per-bit edge events latched into a write-1-to-clear status register and
// a registered level interrupt.
//
// Handshake: a channel transfers on a clock edge where its valid and ready
// are both high. awready/wready are a combinational one-cycle pulse offered
// only when the write FSM is idle, the address hits and both awvalid and
// wvalid are present; arready likewise for reads. bvalid/rvalid are held,
// with bresp/rresp/rdata stable, until the edge where bready/rready is seen.
// Misses never raise a ready so another slave may claim the access.
//
// dbg_state = {write FSM in RESP, read FSM in RESP}.
module gpio #(
    parameter logic [31:0] addrBase = 32'h0,
    parameter int          GPIO_W   = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    AXI4bus.Slave             axiBus,
    input  logic [GPIO_W-1:0] gpio_i,
    output logic [GPIO_W-1:0] gpio_o,
    output logic [GPIO_W-1:0] gpio_oe,
    output logic              Int,
    output logic [1:0]        dbg_state
);

    // Mask covering the GPIO_W pin bits; upper register bits read 0 and drop writes.
    localparam logic [31:0] IMPL_MASK = (GPIO_W >= 32) ? 32'hFFFF_FFFF
                                                       : ((32'h1 << GPIO_W) - 32'h1);

    localparam logic [2:0] OFF_DATA_OUT = 3'd0;
    localparam logic [2:0] OFF_OE       = 3'd1;
    localparam logic [2:0] OFF_DATA_IN  = 3'd2;
    localparam logic [2:0] OFF_IRQ_EN   = 3'd3;
    localparam logic [2:0] OFF_IRQ_EDGE = 3'd4;
    localparam logic [2:0] OFF_IRQ_STAT = 3'd5;
    localparam logic [2:0] OFF_OUT_SET  = 3'd6;
    localparam logic [2:0] OFF_OUT_CLR  = 3'd7;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_t;

    wr_state_t   wr_state, wr_state_next;
    rd_state_t   rd_state, rd_state_next;

    logic [31:0] data_out;
    logic [31:0] oe;
    logic [31:0] irq_en;
    logic [31:0] irq_edge;
    logic [31:0] irq_stat;
    logic [31:0] s1, s2, s3;
    logic [31:0] pin_ext;
    logic [31:0] edge_event;
    logic [31:0] stat_clr;
    logic [31:0] rdata_q;
    logic [31:0] rd_mux;
    logic        int_q;

    logic        wr_hit, wr_accept;
    logic        rd_hit, rd_accept;
    logic [2:0]  wr_off, rd_off;
    logic [31:0] wr_mask;
    logic [31:0] wr_bits;
    logic        unused_addr_bits;

    assign pin_ext = 32'(gpio_i);

    assign wr_hit  = (axiBus.awaddr[31:5] == addrBase[31:5]);
    assign rd_hit  = (axiBus.araddr[31:5] == addrBase[31:5]);
    assign wr_off  = axiBus.awaddr[4:2];
    assign rd_off  = axiBus.araddr[4:2];

    // Byte lanes with a cleared strobe keep their old contents for every register.
    assign wr_mask = {{8{axiBus.wstrb[3]}}, {8{axiBus.wstrb[2]}},
                      {8{axiBus.wstrb[1]}}, {8{axiBus.wstrb[0]}}} & IMPL_MASK;
    assign wr_bits = axiBus.wdata & wr_mask;

    assign unused_addr_bits = ^{axiBus.awaddr[1:0], axiBus.araddr[1:0]};

    // Write FSM state register.
    always_ff @(posedge Clk) begin
        if (Rst) wr_state <= WR_IDLE;
        else     wr_state <= wr_state_next;
    end

    // Write FSM next state: accept only a complete address+data pair that hits.
    always_comb begin
        wr_state_next = wr_state;
        wr_accept     = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                if (axiBus.awvalid && axiBus.wvalid && wr_hit && !Rst) begin
                    wr_accept     = 1'b1;
                    wr_state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (axiBus.bready) wr_state_next = WR_IDLE;
            end
            default: wr_state_next = WR_IDLE;
        endcase
    end

    assign axiBus.awready = wr_accept;
    assign axiBus.wready  = wr_accept;
    assign axiBus.bvalid  = (wr_state == WR_RESP);
    assign axiBus.bresp   = 2'b00;

    // Read FSM state register.
    always_ff @(posedge Clk) begin
        if (Rst) rd_state <= RD_IDLE;
        else     rd_state <= rd_state_next;
    end

    // Read FSM next state: accept a hitting address, then hold data until rready.
    always_comb begin
        rd_state_next = rd_state;
        rd_accept     = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                if (axiBus.arvalid && rd_hit && !Rst) begin
                    rd_accept     = 1'b1;
                    rd_state_next = RD_RESP;
                end
            end
            RD_RESP: begin
                if (axiBus.rready) rd_state_next = RD_IDLE;
            end
            default: rd_state_next = RD_IDLE;
        endcase
    end

    assign axiBus.arready = rd_accept;
    assign axiBus.rvalid  = (rd_state == RD_RESP);
    assign axiBus.rresp   = 2'b00;
    assign axiBus.rdata   = rdata_q;

    // Read mux over current register values; a same-cycle write is not yet visible.
    always_comb begin
        rd_mux = 32'h0;
        case (rd_off)
            OFF_DATA_OUT: rd_mux = data_out;
            OFF_OE:       rd_mux = oe;
            OFF_DATA_IN:  rd_mux = s2;
            OFF_IRQ_EN:   rd_mux = irq_en;
            OFF_IRQ_EDGE: rd_mux = irq_edge;
            OFF_IRQ_STAT: rd_mux = irq_stat;
            default:      rd_mux = 32'h0;
        endcase
    end

    // Read data register, loaded on the accept edge.
    always_ff @(posedge Clk) begin
        if (Rst)            rdata_q <= 32'h0;
        else if (rd_accept) rdata_q <= rd_mux & IMPL_MASK;
    end

    // Software-writable registers; OUT_SET/OUT_CLR act on DATA_OUT.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            data_out <= 32'h0;
            oe       <= 32'h0;
            irq_en   <= 32'h0;
            irq_edge <= 32'h0;
        end else if (wr_accept) begin
            case (wr_off)
                OFF_DATA_OUT: data_out <= (data_out & ~wr_mask) | wr_bits;
                OFF_OE:       oe       <= (oe       & ~wr_mask) | wr_bits;
                OFF_IRQ_EN:   irq_en   <= (irq_en   & ~wr_mask) | wr_bits;
                OFF_IRQ_EDGE: irq_edge <= (irq_edge & ~wr_mask) | wr_bits;
                OFF_OUT_SET:  data_out <= data_out | wr_bits;
                OFF_OUT_CLR:  data_out <= data_out & ~wr_bits;
                default: ;
            endcase
        end
    end

    // Input synchroniser plus one extra stage for edge detection.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            s1 <= 32'h0;
            s2 <= 32'h0;
            s3 <= 32'h0;
        end else begin
            s1 <= pin_ext & IMPL_MASK;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_event = ((irq_edge & s2 & ~s3) | (~irq_edge & ~s2 & s3)) & IMPL_MASK;
    assign stat_clr   = (wr_accept && (wr_off == OFF_IRQ_STAT)) ? wr_bits : 32'h0;

    // Status latch: W1C clear, with a same-cycle event winning over the clear.
    always_ff @(posedge Clk) begin
        if (Rst) irq_stat <= 32'h0;
        else     irq_stat <= (irq_stat & ~stat_clr) | edge_event;
    end

    // Registered interrupt from enabled pending bits.
    always_ff @(posedge Clk) begin
        if (Rst) int_q <= 1'b0;
        else     int_q <= |(irq_stat & irq_en);
    end

    assign Int       = int_q;
    assign gpio_o    = data_out[GPIO_W-1:0];
    assign gpio_oe   = oe[GPIO_W-1:0];
    assign dbg_state = {wr_state == WR_RESP, rd_state == RD_RESP};

endmodule
